// File: rtl/sti_seq_pkg.sv
// Shared types and helpers for the STI_DAC load sequencer.
package sti_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_WAIT_VALID = 3'd2,
    S_SHIFT      = 3'd3,
    S_DONE       = 3'd4,
    S_ERR        = 3'd5
  } state_t;

  localparam int CFG_LEN_HI = 13;
  localparam int CFG_LEN_LO = 12;
  localparam int CFG_FILL   = 8;
  localparam int CFG_MSB    = 4;
  localparam int CFG_LOW    = 0;

  // Length code 0..3 -> 8/16/24/32 serial bits
  function automatic logic [5:0] len_to_bits(input logic [1:0] len);
    logic [2:0] n;
    n = {1'b0, len} + 3'd1;
    return {n, 3'b000};
  endfunction

endpackage

// File: rtl/sti_seq_wdog.sv
// Load-to-valid watchdog: counts enabled cycles after a clear, flags TIMEOUT-1.
module sti_seq_wdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [7:0] r_cnt;
  logic       w_expired;

  assign w_expired = (r_cnt == 8'(TIMEOUT - 1));
  assign o_expired = w_expired;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_en && !w_expired)
      r_cnt <= r_cnt + 8'd1;
  end

endmodule

// File: rtl/sti_load_sequencer.sv
// Command sequencer for STI_DAC: handshakes commands, pulses load, checks the
// so_valid burst length and flags timeouts / spurious valids.
module sti_load_sequencer
  import sti_seq_pkg::*;
#(
  parameter int TIMEOUT  = 64,
  parameter int BITCNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [15:0]         cmd_data,
  input  logic [15:0]         cmd_cfg,
  input  logic                cmd_last,
  output logic                load,
  output logic [15:0]         pi_data,
  output logic [1:0]          pi_length,
  output logic                pi_fill,
  output logic                pi_msb,
  output logic                pi_low,
  output logic                pi_end,
  input  logic                so_valid,
  output logic                busy,
  output logic                done,
  output logic                err_timeout,
  output logic                err_len,
  output logic                err_spur,
  output logic [7:0]          word_count,
  output logic [BITCNT_W-1:0] bit_count
);

  state_t              r_state;
  logic                r_cmd_ready, r_load, r_busy, r_done, r_last;
  logic [15:0]         r_pi_data;
  logic [1:0]          r_pi_length;
  logic                r_pi_fill, r_pi_msb, r_pi_low, r_pi_end;
  logic                r_err_timeout, r_err_len, r_err_spur;
  logic [7:0]          r_word_count;
  logic [BITCNT_W-1:0] r_bit_count;
  logic [5:0]          r_word_bits;
  logic                w_expired;
  logic                w_unused_cfg;

  assign w_unused_cfg = ^{cmd_cfg[15:14], cmd_cfg[11:9], cmd_cfg[7:5], cmd_cfg[3:1]};

  sti_seq_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (r_state == S_LOAD),
    .i_en      (r_state == S_WAIT_VALID),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cmd_ready   <= 1'b1;
      r_load        <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_last        <= 1'b0;
      r_pi_data     <= '0;
      r_pi_length   <= '0;
      r_pi_fill     <= 1'b0;
      r_pi_msb      <= 1'b0;
      r_pi_low      <= 1'b0;
      r_pi_end      <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_len     <= 1'b0;
      r_err_spur    <= 1'b0;
      r_word_count  <= '0;
      r_bit_count   <= '0;
      r_word_bits   <= '0;
    end else begin
      r_load <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (so_valid) r_err_spur <= 1'b1;
          if (cmd_valid && r_cmd_ready) begin
            r_pi_data   <= cmd_data;
            r_pi_length <= cmd_cfg[CFG_LEN_HI:CFG_LEN_LO];
            r_pi_fill   <= cmd_cfg[CFG_FILL];
            r_pi_msb    <= cmd_cfg[CFG_MSB];
            r_pi_low    <= cmd_cfg[CFG_LOW];
            r_last      <= cmd_last;
            if (cmd_last) r_pi_end <= 1'b1;
            r_load      <= 1'b1;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (so_valid) r_err_spur <= 1'b1;
          r_state <= S_WAIT_VALID;
        end
        S_WAIT_VALID: begin
          // A valid arriving on the expiry cycle still wins over the timeout
          if (so_valid) begin
            r_word_bits <= 6'd1;
            if (r_bit_count != '1) r_bit_count <= r_bit_count + 1'b1;
            r_state <= S_SHIFT;
          end else if (w_expired) begin
            r_err_timeout <= 1'b1;
            r_state       <= S_ERR;
          end
        end
        S_SHIFT: begin
          if (so_valid) begin
            if (r_word_bits != 6'd63) r_word_bits <= r_word_bits + 6'd1;
            if (r_bit_count != '1) r_bit_count <= r_bit_count + 1'b1;
          end else begin
            if (r_word_bits != len_to_bits(r_pi_length)) r_err_len <= 1'b1;
            r_word_count <= r_word_count + 8'd1;
            r_busy       <= 1'b0;
            if (r_last) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_cmd_ready <= 1'b1;
              r_state     <= S_IDLE;
            end
          end
        end
        S_DONE:  r_state <= S_DONE;
        S_ERR:   r_state <= S_ERR;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign load        = r_load;
  assign pi_data     = r_pi_data;
  assign pi_length   = r_pi_length;
  assign pi_fill     = r_pi_fill;
  assign pi_msb      = r_pi_msb;
  assign pi_low      = r_pi_low;
  assign pi_end      = r_pi_end;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err_timeout = r_err_timeout;
  assign err_len     = r_err_len;
  assign err_spur    = r_err_spur;
  assign word_count  = r_word_count;
  assign bit_count   = r_bit_count;

endmodule

// File: tb/tb_sti_load_sequencer.sv
// Scoreboard bench for sti_load_sequencer: stimulus pushes expected load
// contents, a negedge monitor checks every load pulse against them.
module tb_sti_load_sequencer;

  localparam int TIMEOUT  = 64;
  localparam int BITCNT_W = 7;

  logic clk = 1'b0, reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_last = 1'b0, so_valid = 1'b0;
  logic [15:0] cmd_data = '0, cmd_cfg = '0;
  logic cmd_ready, load, pi_fill, pi_msb, pi_low, pi_end;
  logic busy, done, err_timeout, err_len, err_spur;
  logic [15:0] pi_data;
  logic [1:0]  pi_length;
  logic [7:0]  word_count;
  logic [BITCNT_W-1:0] bit_count;

  sti_load_sequencer #(.TIMEOUT(TIMEOUT), .BITCNT_W(BITCNT_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_cfg(cmd_cfg), .cmd_last(cmd_last), .load(load),
    .pi_data(pi_data), .pi_length(pi_length), .pi_fill(pi_fill), .pi_msb(pi_msb),
    .pi_low(pi_low), .pi_end(pi_end), .so_valid(so_valid), .busy(busy), .done(done),
    .err_timeout(err_timeout), .err_len(err_len), .err_spur(err_spur),
    .word_count(word_count), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  len;
    logic        fill, msb, low, pend;
    int          cyc;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every load pulse must match the oldest issued command
  logic prev_load = 1'b0;
  always @(negedge clk) begin
    if (!reset && load) begin
      chk("load_single_cycle", 32'(prev_load), 0);
      if (q.size() == 0) chk("load_unexpected", 32'(load), 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("load_latency", cyc, e.cyc);
        chk("pi_data", 32'(pi_data), 32'(e.data));
        chk("pi_length", 32'(pi_length), 32'(e.len));
        chk("pi_fill", 32'(pi_fill), 32'(e.fill));
        chk("pi_msb", 32'(pi_msb), 32'(e.msb));
        chk("pi_low", 32'(pi_low), 32'(e.low));
        chk("pi_end", 32'(pi_end), 32'(e.pend));
      end
    end
    prev_load = load;
  end

  task automatic do_reset();
    reset = 1'b1; cmd_valid = 1'b0; so_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Returns #1 after the handshake edge, i.e. inside the load cycle
  task automatic issue(input logic [15:0] d, input logic [15:0] c, input logic last);
    int n = 0;
    exp_t e;
    cmd_data = d; cmd_cfg = c; cmd_last = last; cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      chk("handshake_timeout", 32'(cmd_ready), 1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    e.data = d; e.len = c[13:12]; e.fill = c[8]; e.msb = c[4]; e.low = c[0];
    e.pend = last; e.cyc = cyc;
    q.push_back(e);
  endtask

  // Converter model: valid from the first WAIT_VALID cycle for nb cycles
  task automatic burst(input int nb, input logic last);
    @(posedge clk); #1;
    so_valid = 1'b1;
    repeat (nb) begin @(posedge clk); #1; end
    so_valid = 1'b0;
    chk("ready_low_at_fall", 32'(cmd_ready), 0);
    @(posedge clk); #1;
    chk("ready_after_fall", 32'(cmd_ready), last ? 0 : 1);
    chk("done_after_fall", 32'(done), 32'(last));
  endtask

  task automatic run(input logic [15:0] d, input logic [15:0] c, input logic last, input int nb);
    issue(d, c, last);
    burst(nb, last);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int n;
    do_reset();
    // Reset state
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_load", 32'(load), 0);
    chk("rst_pi_end", 32'(pi_end), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_counts", {word_count, 24'(bit_count)}, 0);

    // Single 8-bit last command
    run(16'hA55A, 16'h0000, 1'b1, 8);
    chk("t1_word_count", 32'(word_count), 1);
    chk("t1_bit_count", 32'(bit_count), 8);
    chk("t1_errs", {err_timeout, err_len, err_spur}, 0);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_pi_end", 32'(pi_end), 1);

    // Four back-to-back commands, length codes 0..3
    do_reset();
    run(16'h1111, 16'h0100, 1'b0, 8);
    run(16'h2222, 16'h1010, 1'b0, 16);
    run(16'h3333, 16'h2001, 1'b0, 24);
    run(16'h4444, 16'h3111, 1'b1, 32);
    chk("t2_word_count", 32'(word_count), 4);
    chk("t2_bit_count", 32'(bit_count), 80);
    chk("t2_err_len", 32'(err_len), 0);

    // Short burst -> err_len sticky, next command still runs
    do_reset();
    run(16'h0F0F, 16'h1000, 1'b0, 15);
    chk("t3_err_len_set", 32'(err_len), 1);
    run(16'hF0F0, 16'h0000, 1'b1, 8);
    chk("t3_err_len_sticky", 32'(err_len), 1);
    chk("t3_word_count", 32'(word_count), 2);
    chk("t3_bit_count", 32'(bit_count), 23);

    // No so_valid -> timeout after TIMEOUT wait cycles
    do_reset();
    issue(16'h1234, 16'h0000, 1'b0);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (err_timeout) break;
      n++;
    end
    chk("t4_wait_cycles", n, TIMEOUT);
    chk("t4_err_timeout", 32'(err_timeout), 1);
    chk("t4_busy", 32'(busy), 1);
    chk("t4_ready", 32'(cmd_ready), 0);
    cmd_data = 16'hDEAD; cmd_cfg = 16'h0; cmd_last = 1'b1; cmd_valid = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    cmd_valid = 1'b0;
    chk("t4_ready_hold", 32'(cmd_ready), 0);
    chk("t4_done", 32'(done), 0);

    // Spurious valid in IDLE
    do_reset();
    so_valid = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    so_valid = 1'b0;
    chk("t5_err_spur", 32'(err_spur), 1);
    chk("t5_bit_count", 32'(bit_count), 0);
    chk("t5_idle_ready", 32'(cmd_ready), 1);
    chk("t5_busy", 32'(busy), 0);
    run(16'h5A5A, 16'h0000, 1'b1, 8);
    chk("t5_bit_count_after", 32'(bit_count), 8);
    chk("t5_err_len", 32'(err_len), 0);

    // Reset mid-burst of a 32-bit word
    do_reset();
    issue(16'hBEEF, 16'h3000, 1'b1);
    @(posedge clk); #1;
    so_valid = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    chk("t6_ready", 32'(cmd_ready), 1);
    chk("t6_pi_end", 32'(pi_end), 0);
    chk("t6_pi_data", 32'(pi_data), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_counts", {word_count, 24'(bit_count)}, 0);
    chk("t6_errs", {err_timeout, err_len, err_spur}, 0);
    so_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    run(16'h00A5, 16'h0000, 1'b1, 8);
    chk("t6_clean_errs", {err_timeout, err_len, err_spur}, 0);
    chk("t6_clean_bits", 32'(bit_count), 8);
    chk("t6_clean_words", 32'(word_count), 1);

    // Saturation of the bit counter (4 x 32 = 128 > 127)
    do_reset();
    run(16'h0001, 16'h3000, 1'b0, 32);
    run(16'h0002, 16'h3000, 1'b0, 32);
    run(16'h0003, 16'h3000, 1'b0, 32);
    run(16'h0004, 16'h3000, 1'b1, 32);
    chk("t7_bit_sat", 32'(bit_count), 127);
    chk("t7_word_count", 32'(word_count), 4);
    chk("t7_err_len", 32'(err_len), 0);

    repeat (2) @(posedge clk);
    chk("sb_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sti_load_sequencer.md
Name: sti_load_sequencer

Overview:
Command-level controller in front of the STI_DAC parallel-to-serial converter. Accepts (data, config) command words from an upstream requester over a valid/ready handshake and issues each one to the converter with a one-cycle load pulse. It then tracks the resulting so_valid burst, checks the emitted bit count against the programmed length, and asserts pi_end on the final command. It replaces ad-hoc load/pi_end sequencing with a checked, timed handshake.

Parameters:
TIMEOUT, 64, max cycles from load pulse to so_valid rise before timeout error (min 2, max 255)
BITCNT_W, 16, width of saturating total serial-bit counter

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  upstream command present
cmd_ready  output  1  sequencer can accept command
cmd_data  input  16  parallel data word, forwarded to pi_data
cmd_cfg  input  16  config word: [13:12] length code, [8] fill, [4] msb-first, [0] low-half select
cmd_last  input  1  final command of the stream
load  output  1  one-cycle load pulse to converter
pi_data  output  16  registered data word
pi_length  output  2  registered cmd_cfg[13:12]
pi_fill  output  1  registered cmd_cfg[8]
pi_msb  output  1  registered cmd_cfg[4]
pi_low  output  1  registered cmd_cfg[0]
pi_end  output  1  end-of-stream flag to converter
so_valid  input  1  converter serial-output valid
busy  output  1  high in any state except IDLE and DONE
done  output  1  stream finished cleanly or with length error
err_timeout  output  1  sticky: so_valid never rose within TIMEOUT
err_len  output  1  sticky: burst length differed from expected
err_spur  output  1  sticky: so_valid high in IDLE or LOAD
word_count  output  8  commands completed, wraps at 256
bit_count  output  BITCNT_W  total so_valid-high cycles counted, saturating

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0 except cmd_ready=1. Counters, flags and pi_* registers are cleared. A reset asserted mid-burst abandons the burst with no error recorded.
- States: IDLE, LOAD, WAIT_VALID, SHIFT, DONE, ERR. Encoding is binary.
- IDLE: cmd_ready=1. A handshake on the same edge (cmd_valid&cmd_ready) captures cmd_data, cmd_cfg fields and cmd_last, then moves to LOAD.
- LOAD: load=1 for exactly one cycle, the cycle after the handshake. If the captured last=1, pi_end goes to 1 in this cycle and stays at 1 until reset. Timer is cleared. Next state is WAIT_VALID.
- pi_data and pi_* hold their values from capture until the next capture. They never change while load or so_valid is high.
- WAIT_VALID: timer increments each cycle. On so_valid=1: go to SHIFT, word_bits=1, bit_count+1. If the timer reaches TIMEOUT-1 with so_valid=0: go to ERR.
- SHIFT: each cycle with so_valid=1 increments word_bits (6-bit, saturates at 63) and bit_count. On the first so_valid=0:
  - Expected bits = 8*(pi_length+1), i.e. 8/16/24/32.
  - If word_bits != expected, set err_len.
  - word_count increments.
  - If last: go to DONE, else go to IDLE.
- Back-to-back throughput: the next cmd_ready appears one cycle after so_valid falls.
- DONE: done=1, cmd_ready=0, busy=0. Holds until reset; commands are not accepted.
- ERR: err_timeout=1, cmd_ready=0, busy=1. Holds until reset.
- so_valid=1 in IDLE or LOAD sets err_spur. Those cycles are not counted and cause no state change.
- err_len does not stop sequencing; later commands continue.
- bit_count holds at all-ones once saturated.

Decomposition:
- Package sti_seq_pkg contains:
  - state enum
  - cfg bit positions (LEN_HI=13, LEN_LO=12, FILL=8, MSB=4, LOW=0)
  - function len_to_bits(2-bit) returning 6-bit 8/16/24/32
- One natural sub-module, sti_seq_wdog: the load-to-valid timeout counter with clear/enable/expired.

Test Plan:
- Single command, cmd_cfg=16'h0000 (8-bit), cmd_last=1; converter model gives 8 so_valid cycles -> load pulses once 1 cycle after handshake, pi_end=1 from the load cycle, done=1, word_count=1, bit_count=8, all errors 0.
- Four back-to-back commands with length codes 0..3, last on the 4th -> four single-cycle loads, bit_count=8+16+24+32=80, word_count=4, err_len=0, cmd_ready re-asserts 1 cycle after each so_valid fall.
- Length code 1 but model emits 15 bits -> err_len=1 sticky, sequencing continues, next command accepted normally.
- Model never raises so_valid, TIMEOUT=64 -> ERR entered 64 cycles after the load cycle, err_timeout=1, cmd_ready=0 thereafter.
- so_valid forced high 2 cycles while in IDLE -> err_spur=1, bit_count unchanged, state stays IDLE.
- Assert reset mid-SHIFT of a 32-bit word -> all outputs cleared at once, cmd_ready=1, pi_end=0; next stream runs cleanly.
